// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// State encoding is fixed at 2 bits.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int          CH_NUM  = 4;
   localparam int          SEL_W   = 2;
   localparam logic [1:0]  LAST_CH = 2'd3;

endpackage

// File: rtl/mux_scan_sequencer_settle_timer.sv
// Settle down-counter: load sets the count, dec steps it toward zero.
// Zero flag comes straight from the count register.
module settle_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the 4:1 mux selects through ch0..ch3, samples y after a settle time and
// delivers a 4-bit frame on valid/ready. Optional frame_par port under SCAN_PARITY_EN.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mux_y,
   output logic       s0,
   output logic       s1,
   output logic [3:0] frame,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       busy
`ifdef SCAN_PARITY_EN
   ,
   output logic       frame_par
`endif
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t            state_q;
   logic [SEL_W-1:0]  sel_q;
   logic [CH_NUM-1:0] frame_q;
   logic [CH_NUM-1:0] frame_d;
   logic              valid_q;
   logic              busy_q;
   logic              tmr_load;
   logic              tmr_dec;
   logic              tmr_zero;

   settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (RELOAD),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Timer is reloaded on every transition into SETTLE.
   always_comb begin
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      frame_d  = frame_q;
      frame_d[sel_q] = mux_y;
      case (state_q)
         IDLE:    tmr_load = start;
         SETTLE:  tmr_dec  = !tmr_zero;
         SAMPLE:  tmr_load = (sel_q != LAST_CH);
         HOLD:    tmr_load = frame_ready && start;
         default: tmr_load = 1'b0;
      endcase
   end

`ifdef SCAN_PARITY_EN
   logic par_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         frame_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SCAN_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  sel_q   <= '0;
                  state_q <= SETTLE;
                  busy_q  <= 1'b1;
               end
            end
            SETTLE: begin
               if (tmr_zero) state_q <= SAMPLE;
            end
            SAMPLE: begin
               frame_q <= frame_d;
               if (sel_q != LAST_CH) begin
                  sel_q   <= sel_q + SEL_W'(1);
                  state_q <= SETTLE;
               end else begin
                  valid_q <= 1'b1;
                  state_q <= HOLD;
`ifdef SCAN_PARITY_EN
                  par_q   <= ^frame_d;
`endif
               end
            end
            HOLD: begin
               // Handshake edge: restart immediately if start is also high.
               if (frame_ready) begin
                  valid_q <= 1'b0;
                  if (start) begin
                     sel_q   <= '0;
                     state_q <= SETTLE;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s0          = sel_q[0];
   assign s1          = sel_q[1];
   assign frame       = frame_q;
   assign frame_valid = valid_q;
   assign busy        = busy_q;
`ifdef SCAN_PARITY_EN
   assign frame_par   = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: directed scenarios plus random traffic against a
// timing-arithmetic reference model; the 4:1 mux is modelled inline.
module tb_mux_scan_sequencer;

   localparam int S = 2;
   localparam int P = S + 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       frame_ready;
   logic       a, b, c, d;
   logic       s0, s1;
   logic [3:0] frame;
   logic       frame_valid;
   logic       busy;
   logic       mux_y;
`ifdef SCAN_PARITY_EN
   logic       frame_par;
`endif

   assign mux_y = s1 ? (s0 ? d : c) : (s0 ? b : a);

   always #5 clk = ~clk;

   mux_scan_sequencer #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mux_y       (mux_y),
      .s0          (s0),
      .s1          (s1),
      .frame       (frame),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .busy        (busy)
`ifdef SCAN_PARITY_EN
      ,
      .frame_par   (frame_par)
`endif
   );

   int tests = 0;
   int fails = 0;
   int edge_n = 0;

   // Reference model: a scan accepted at edge t0 samples channel i at edge t0+(i+1)*P.
   bit         m_active;
   bit         m_valid;
   int         m_t0;
   logic [3:0] m_frame;
   logic [1:0] m_sel;
   logic       m_par;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_valid  = 0;
      m_t0     = 0;
      m_frame  = 4'b0000;
      m_sel    = 2'd0;
      m_par    = 1'b0;
   endtask

   task automatic step();
      logic [3:0] vin;
      int k;
      int ch;
      @(posedge clk);
      edge_n++;
      vin = {d, c, b, a};
      if (m_valid) begin
         if (frame_ready) begin
            m_valid = 0;
            if (start) begin m_active = 1; m_t0 = edge_n; m_sel = 2'd0; end
         end
      end else if (!m_active) begin
         if (start) begin m_active = 1; m_t0 = edge_n; m_sel = 2'd0; end
      end else begin
         k = edge_n - m_t0;
         if (k % P == 0) begin
            ch = k / P - 1;
            m_frame[ch] = vin[ch];
            if (ch == 3) begin
               m_active = 0;
               m_valid  = 1;
               m_par    = ^m_frame;
            end else begin
               m_sel = 2'(ch + 1);
            end
         end
      end
      #1;
      check("frame", 32'(frame), 32'(m_frame));
      check("valid", 32'(frame_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_active || m_valid));
      check("sel", 32'({s1, s0}), 32'(m_sel));
`ifdef SCAN_PARITY_EN
      check("par", 32'(frame_par), 32'(m_par));
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_frame"}, 32'(frame), 32'd0);
      check({tag, "_valid"}, 32'(frame_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_sel"}, 32'({s1, s0}), 32'd0);
`ifdef SCAN_PARITY_EN
      check({tag, "_par"}, 32'(frame_par), 32'd0);
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check_reset_outputs("rst");
      model_reset();
      @(posedge clk);
      edge_n++;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_in(input logic [3:0] v);
      {d, c, b, a} = v;
   endtask

   initial begin
      int lat;
      int rises[$];
      bit prev_v;
      rst_n = 1'b0;
      start = 1'b0;
      frame_ready = 1'b0;
      set_in(4'b0000);
      model_reset();
      #2;
      check_reset_outputs("init");
      @(posedge clk); edge_n++;
      @(posedge clk); edge_n++;
      #1;
      rst_n = 1'b1;
      step();

      // Single scan: a=0,b=1,c=0,d=1 -> frame 1010 after 12 edges.
      set_in(4'b1010);
      start = 1'b1;
      step();
      start = 1'b0;
      lat = 0;
      while (!frame_valid && lat < 40) begin step(); lat++; end
      check("single_latency", 32'(lat), 32'd12);
      check("single_frame", 32'(frame), 32'b1010);

      // Back-pressure: inputs change while held, frame must not move.
      for (int i = 0; i < 5; i++) begin
         set_in(4'($urandom));
         step();
      end
      check("bp_frame", 32'(frame), 32'b1010);
      check("bp_valid", 32'(frame_valid), 32'd1);
      frame_ready = 1'b1;
      step();
      check("bp_valid_drop", 32'(frame_valid), 32'd0);

      // Back-to-back: a=1,b=1,c=0,d=0 -> 0011 every 13 cycles.
      set_in(4'b0011);
      start = 1'b1;
      prev_v = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (frame_valid && !prev_v) begin
            rises.push_back(edge_n);
            check("b2b_frame", 32'(frame), 32'b0011);
         end
         if (!frame_valid && prev_v) check("b2b_sel_restart", 32'({s1, s0}), 32'd0);
         prev_v = frame_valid;
      end
      check("b2b_count", 32'(rises.size() >= 3), 32'd1);
      for (int i = 1; i < rises.size(); i++)
         check("b2b_period", 32'(rises[i] - rises[i-1]), 32'd13);
      start = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("b2b_idle", 32'(busy), 32'd0);

      // Start pulses mid-scan are ignored; latency stays 12.
      set_in(4'b1101);
      frame_ready = 1'b0;
      start = 1'b1;
      step();
      for (int i = 0; i < 11; i++) begin
         start = 1'(i % 2);
         step();
      end
      start = 1'b0;
      lat = 11;
      while (!frame_valid && lat < 40) begin step(); lat++; end
      check("ign_latency", 32'(lat), 32'd12);
      check("ign_frame", 32'(frame), 32'b1101);
`ifdef SCAN_PARITY_EN
      check("par_1101", 32'(frame_par), 32'd1);
`endif
      frame_ready = 1'b1;
      step();
      check("ign_idle", 32'(busy), 32'd0);

      // Reset in the middle of ch2 settle.
      set_in(4'b0110);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 2 * P + 1; i++) step();
      check("pre_rst_sel", 32'({s1, s0}), 32'd2);
      do_reset();
      step();
      check("post_rst_busy", 32'(busy), 32'd0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         set_in(4'($urandom));
         start = ($urandom_range(0, 3) == 0);
         frame_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 499) == 0) do_reset();
         else step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
